uart_tx_buffered: RTL

Buffered UART transmitter that sits in front of the TxD pin. A small synchronous FIFO accepts bytes over a valid/ready handshake, and a framing FSM serialises them as 8N1/8E1/8O1/8N2 frames. Frames are sent back to back with no idle gap while the FIFO holds data. The serial output is line-compatible with the team's existing 16x-oversampling receiver and is intended to replace the single-byte transmitter in the loopback interface.

---
 rtl/uart_tx_buffered.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: a small synchronous FIFO takes bytes over a
// valid/ready handshake and a framing FSM serialises them onto TxD as
// 8N1 / 8E1 / 8O1 / 8N2 frames. While the FIFO holds data, frames follow
// each other with no idle bit in between.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | line high, waiting for the FIFO to hold a byte
// START  | driving the start bit (low) for one bit period
// DATA   | driving data bits 0..7, LSB first
// PARITY | driving the parity bit (only when parity_en != 0)
// STOP   | driving stop_bits high bit periods, then pop or go idle
module uart_tx_buffered #(
   parameter int clk_freq   = 50_000_000,
   parameter int baud_rate  = 115200,
   parameter int fifo_depth = 8,
   parameter int parity_en  = 0,
   parameter int parity_odd = 0,
   parameter int stop_bits  = 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          in_valid,
   input  logic [7:0]                    in_data,
   output logic                          in_ready,
   output logic                          TxD,
   output logic                          busy,
   output logic                          tx_done,
   output logic [$clog2(fifo_depth):0]   fifo_count
);

   localparam int DIV = clk_freq / baud_rate;
   localparam int CW  = $clog2(DIV);
   localparam int AW  = $clog2(fifo_depth);

   localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
   localparam logic [AW:0]   DEPTH     = (AW+1)'(fifo_depth);
   localparam logic [2:0]    STOP_LAST = 3'(stop_bits - 1);
   localparam logic          PAR_ODD   = (parity_odd != 0);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t         state;
   state_t         state_nx;
   logic [7:0]     mem [fifo_depth];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic [7:0]     shreg;
   logic [CW-1:0]  baud_cnt;
   logic [CW-1:0]  cnt_nx;
   logic [2:0]     bit_idx;
   logic [2:0]     idx_nx;
   logic           txd_nx;
   logic           done_nx;
   logic           push;
   logic           pop;
   logic           bit_end;
   logic           par_bit;

   // in_ready looks only at the registered count, so a same-cycle pop
   // never opens a slot in a full FIFO.
   assign in_ready = (fifo_count < DEPTH);
   assign busy     = (state != IDLE) || (fifo_count != '0);
   assign push     = in_valid && in_ready;
   assign bit_end  = (baud_cnt == BAUD_LAST);
   // shreg is only reloaded at a pop, so this stays stable for the whole frame
   assign par_bit  = (^shreg) ^ PAR_ODD;

   // FIFO storage write port
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= in_data;
      end
   end

   // next-state, line level and pop decisions for the framing FSM
   always_comb begin
      state_nx = state;
      txd_nx   = TxD;
      done_nx  = 1'b0;
      pop      = 1'b0;
      idx_nx   = bit_idx;
      cnt_nx   = bit_end ? '0 : baud_cnt + 1'b1;
      case (state)
         IDLE: begin
            txd_nx = 1'b1;
            cnt_nx = '0;
            idx_nx = '0;
            if (fifo_count != '0) begin
               pop      = 1'b1;
               txd_nx   = 1'b0;
               state_nx = START;
            end
         end
         START: begin
            if (bit_end) begin
               txd_nx   = shreg[0];
               idx_nx   = '0;
               state_nx = DATA;
            end
         end
         DATA: begin
            if (bit_end) begin
               if (bit_idx == 3'd7) begin
                  idx_nx = '0;
                  if (parity_en != 0) begin
                     txd_nx   = par_bit;
                     state_nx = PARITY;
                  end else begin
                     txd_nx   = 1'b1;
                     state_nx = STOP;
                  end
               end else begin
                  idx_nx = bit_idx + 3'd1;
                  txd_nx = shreg[bit_idx + 3'd1];
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               txd_nx   = 1'b1;
               idx_nx   = '0;
               state_nx = STOP;
            end
         end
         STOP: begin
            if (bit_end) begin
               if (bit_idx == STOP_LAST) begin
                  done_nx = 1'b1;
                  idx_nx  = '0;
                  // chain straight into the next start bit when data is waiting
                  if (fifo_count != '0) begin
                     pop      = 1'b1;
                     txd_nx   = 1'b0;
                     state_nx = START;
                  end else begin
                     state_nx = IDLE;
                  end
               end else begin
                  idx_nx = bit_idx + 3'd1;
               end
            end
         end
         default: begin
            txd_nx   = 1'b1;
            state_nx = IDLE;
         end
      endcase
   end

   // state register, registered outputs, FIFO pointers and count
   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         TxD        <= 1'b1;
         tx_done    <= 1'b0;
         baud_cnt   <= '0;
         bit_idx    <= '0;
         shreg      <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         state    <= state_nx;
         TxD      <= txd_nx;
         tx_done  <= done_nx;
         baud_cnt <= cnt_nx;
         bit_idx  <= idx_nx;
         if (pop) begin
            shreg  <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

endmodule
